// File: rtl/omega_conf_writer_8x8_if.sv
// Configuration handshake between a caller and the omega conf writer.
// The caller is the master; the writer consumes through the slave view.
interface omega_conf_writer_8x8_if #(
    parameter int NUM_SW = 12,
    parameter int SEL_W  = 2
);
    logic                      conf_valid;
    logic                      conf_ready;
    logic [NUM_SW*SEL_W-1:0]   conf_data;
    logic                      conf_force;

    modport master (
        output conf_valid,
        output conf_data,
        output conf_force,
        input  conf_ready
    );

    modport slave (
        input  conf_valid,
        input  conf_data,
        input  conf_force,
        output conf_ready
    );
endinterface

// File: rtl/omega_conf_writer_8x8.sv
// Serialises a 24-bit switch-setting vector into addressed bus words,
// skipping switches whose setting matches the shadow unless forced.
module omega_conf_writer_8x8 #(
    parameter int NUM_SW = 12,
    parameter int SEL_W  = 2,
    parameter int ID_W   = 8,
    parameter int BUS_W  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    omega_conf_writer_8x8_if.slave conf,
    output logic [BUS_W-1:0]     net_conf_bus_out,
    output logic                 busy,
    output logic                 done
);

    localparam int CONF_W = NUM_SW * SEL_W;
    localparam int IDX_W  = $clog2(NUM_SW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q,  state_d;
    logic [CONF_W-1:0] hold_q,   hold_d;
    logic              force_q,  force_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [CONF_W-1:0] shadow_q, shadow_d;
    logic              sv_q,     sv_d;
    logic [BUS_W-1:0]  bus_q,    bus_d;

    logic [SEL_W-1:0]  cur_sel;
    logic [SEL_W-1:0]  old_sel;
    logic [ID_W-1:0]   sw_id;
    logic [BUS_W-1:0]  slot_word;
    logic              send_slot;
    logic              last_slot;
    logic              accept;

    assign conf.conf_ready  = (state_q == S_IDLE);
    assign accept           = conf.conf_valid & conf.conf_ready;
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign net_conf_bus_out = bus_q;

    // Pick the new and previously committed setting of the current slot.
    always_comb begin
        cur_sel = '0;
        old_sel = '0;
        for (int k = 0; k < NUM_SW; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_sel = hold_q[k*SEL_W +: SEL_W];
                old_sel = shadow_q[k*SEL_W +: SEL_W];
            end
        end
    end

    assign send_slot = force_q | (cur_sel != old_sel);
    assign last_slot = (idx_q == IDX_W'(NUM_SW - 1));
    assign sw_id     = ID_W'(idx_q) + ID_W'(1);

    always_comb begin
        slot_word                        = '0;
        slot_word[0]                     = 1'b1;
        slot_word[ID_W:1]                = sw_id;
        slot_word[ID_W+SEL_W:ID_W+1]     = cur_sel;
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        force_d  = force_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        sv_d     = sv_q;
        bus_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hold_d  = conf.conf_data;
                    force_d = conf.conf_force | ~sv_q;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (send_slot) begin
                    bus_d = slot_word;
                    for (int k = 0; k < NUM_SW; k++) begin
                        if (idx_q == IDX_W'(k))
                            shadow_d[k*SEL_W +: SEL_W] = cur_sel;
                    end
                end
                if (last_slot) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                sv_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            force_q  <= 1'b0;
            idx_q    <= '0;
            shadow_q <= '0;
            sv_q     <= 1'b0;
            bus_q    <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            force_q  <= force_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            sv_q     <= sv_d;
            bus_q    <= bus_d;
        end
    end

endmodule

// File: tb/tb_omega_conf_writer_8x8.sv
// Directed bench for omega_conf_writer_8x8: slot timing, shadow
// suppression, forced rewrite, busy-time valid and mid-sequence reset.
module tb_omega_conf_writer_8x8;

    logic        clk;
    logic        rst;
    logic [63:0] bus;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    logic [63:0] exp_w [1:14];
    logic [23:0] m_shadow;
    logic        m_sv;

    omega_conf_writer_8x8_if #(.NUM_SW(12), .SEL_W(2)) cif ();

    omega_conf_writer_8x8 dut (
        .clk              (clk),
        .rst              (rst),
        .conf             (cif.slave),
        .net_conf_bus_out (bus),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bus per cycle 1..14 after an acceptance in cycle 0.
    task automatic build_expect(input logic [23:0] d, input logic f);
        logic       ef;
        logic [1:0] s;
        ef = f | ~m_sv;
        for (int c = 1; c <= 14; c++) exp_w[c] = 64'h0;
        for (int k = 1; k <= 12; k++) begin
            s = d[2*k-2 +: 2];
            if (ef || s != m_shadow[2*k-2 +: 2]) begin
                exp_w[k+1] = {53'h0, s, 8'(k), 1'b1};
                m_shadow[2*k-2 +: 2] = s;
            end
        end
        m_sv = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cif.conf_valid = 1'b1;
        cif.conf_data  = 24'hFFFFFF;
        cif.conf_force = 1'b1;
        m_shadow = '0;
        m_sv     = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_bus got %h want 0", bus);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy_done got %b%b want 00", busy, done);
        end
        vectors++;
        if (cif.conf_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 1", cif.conf_ready);
        end
        rst = 1'b0;
        cif.conf_valid = 1'b0;
        cif.conf_force = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_accept got busy=%b want 0", busy);
        end
    endtask

    task automatic test_first;
        build_expect(24'h000000, 1'b0);
        @(negedge clk);
        cif.conf_valid = 1'b1;
        cif.conf_data  = 24'h000000;
        cif.conf_force = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            cif.conf_valid = 1'b0;
            vectors++;
            if (bus !== exp_w[c]) begin
                miscompares++;
                $display("FAIL first_bus c=%0d got %h want %h", c, bus, exp_w[c]);
            end
            if (c == 2) begin
                vectors++;
                if (bus !== 64'h3) begin
                    miscompares++;
                    $display("FAIL first_id1 got %h want 3", bus);
                end
            end
            vectors++;
            if (busy !== (c <= 13) || done !== (c == 13)) begin
                miscompares++;
                $display("FAIL first_flags c=%0d got busy=%b done=%b", c, busy, done);
            end
            vectors++;
            if (cif.conf_ready !== (c == 14)) begin
                miscompares++;
                $display("FAIL first_ready c=%0d got %b want %b", c, cif.conf_ready, (c == 14));
            end
        end
    endtask

    task automatic test_delta;
        build_expect(24'h000300, 1'b0);
        @(negedge clk);
        cif.conf_valid = 1'b1;
        cif.conf_data  = 24'h000300;
        cif.conf_force = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            cif.conf_valid = 1'b0;
            vectors++;
            if (bus !== exp_w[c]) begin
                miscompares++;
                $display("FAIL delta_bus c=%0d got %h want %h", c, bus, exp_w[c]);
            end
            if (c == 6) begin
                vectors++;
                if (bus !== 64'h60B) begin
                    miscompares++;
                    $display("FAIL delta_sw5 got %h want 60b", bus);
                end
            end
            vectors++;
            if (done !== (c == 13)) begin
                miscompares++;
                $display("FAIL delta_done c=%0d got %b want %b", c, done, (c == 13));
            end
        end
    endtask

    task automatic test_same_and_force;
        for (int f = 0; f < 2; f++) begin
            build_expect(24'h000300, f[0]);
            @(negedge clk);
            cif.conf_valid = 1'b1;
            cif.conf_data  = 24'h000300;
            cif.conf_force = f[0];
            for (int c = 1; c <= 14; c++) begin
                @(negedge clk);
                cif.conf_valid = 1'b0;
                cif.conf_force = 1'b0;
                vectors++;
                if (bus !== exp_w[c]) begin
                    miscompares++;
                    $display("FAIL same_force%0d_bus c=%0d got %h want %h", f, c, bus, exp_w[c]);
                end
                vectors++;
                if (done !== (c == 13)) begin
                    miscompares++;
                    $display("FAIL same_force%0d_done c=%0d got %b", f, c, done);
                end
            end
        end
    endtask

    task automatic test_valid_while_busy;
        build_expect(24'hA5C3F0, 1'b0);
        @(negedge clk);
        cif.conf_valid = 1'b1;
        cif.conf_data  = 24'hA5C3F0;
        cif.conf_force = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            cif.conf_data  = (c < 14) ? 24'($urandom) : 24'hA5C3F0;
            cif.conf_force = (c < 14) ? 1'b1 : 1'b0;
            vectors++;
            if (bus !== exp_w[c]) begin
                miscompares++;
                $display("FAIL hold_bus c=%0d got %h want %h", c, bus, exp_w[c]);
            end
            vectors++;
            if (busy !== (c <= 13) || cif.conf_ready !== (c == 14)) begin
                miscompares++;
                $display("FAIL hold_flags c=%0d got busy=%b ready=%b", c, busy, cif.conf_ready);
            end
        end
        build_expect(24'hA5C3F0, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            cif.conf_valid = 1'b0;
            vectors++;
            if (bus !== exp_w[c]) begin
                miscompares++;
                $display("FAIL hold2_bus c=%0d got %h want %h", c, bus, exp_w[c]);
            end
            vectors++;
            if (busy !== (c <= 13) || done !== (c == 13)) begin
                miscompares++;
                $display("FAIL hold2_flags c=%0d got busy=%b done=%b", c, busy, done);
            end
        end
    endtask

    task automatic test_reset_mid;
        build_expect(24'h123456, 1'b0);
        @(negedge clk);
        cif.conf_valid = 1'b1;
        cif.conf_data  = 24'h123456;
        cif.conf_force = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            cif.conf_valid = 1'b0;
            vectors++;
            if (bus !== exp_w[c]) begin
                miscompares++;
                $display("FAIL mid_bus c=%0d got %h want %h", c, bus, exp_w[c]);
            end
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (bus !== 64'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_abort got bus=%h busy=%b want 0 0", bus, busy);
        end
        vectors++;
        if (cif.conf_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_ready got ready=%b done=%b", cif.conf_ready, done);
        end
        #1 rst = 1'b0;
        m_shadow = '0;
        m_sv     = 1'b0;
        build_expect(24'h123456, 1'b0);
        @(negedge clk);
        cif.conf_valid = 1'b1;
        cif.conf_data  = 24'h123456;
        cif.conf_force = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            cif.conf_valid = 1'b0;
            vectors++;
            if (bus !== exp_w[c]) begin
                miscompares++;
                $display("FAIL rewrite_bus c=%0d got %h want %h", c, bus, exp_w[c]);
            end
            if (c >= 2 && c <= 13) begin
                vectors++;
                if (bus[0] !== 1'b1 || bus[8:1] !== 8'(c - 1)) begin
                    miscompares++;
                    $display("FAIL rewrite_full c=%0d got %h", c, bus);
                end
            end
            vectors++;
            if (done !== (c == 13)) begin
                miscompares++;
                $display("FAIL rewrite_done c=%0d got %b", c, done);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst            = 1'b1;
        cif.conf_valid = 1'b0;
        cif.conf_data  = '0;
        cif.conf_force = 1'b0;
        test_reset();
        test_first();
        test_delta();
        test_same_and_force();
        test_valid_while_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/omega_conf_writer_8x8.md
# omega_conf_writer_8x8

Configuration-bus writer for the 8x8 three-stage omega network; it is the producer that drives the network's `net_conf_bus_in`. It accepts a complete 24-bit switch-setting vector for the 12 `switch_box2x2` instances over a valid/ready handshake. It serialises the vector into one addressed 64-bit bus word per switch, which the per-switch configuration controls capture as the word ripples down the bus register chain. A shadow copy of the last committed settings lets the block suppress words for switches whose setting is unchanged, unless the caller forces a full rewrite.

## Interface
Parameters:
- `NUM_SW`, 12, number of switches addressed; switch IDs run 1..`NUM_SW`.
- `SEL_W`, 2, setting width per switch.
- `ID_W`, 8, switch-ID field width.
- `BUS_W`, 64, configuration bus width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `conf_valid`  in  1  caller offers a configuration.
- `conf_ready`  out  1  block accepts; high only in IDLE.
- `conf_data`  in  `NUM_SW*SEL_W`  switch k (1-based) setting in bits [2k-1:2k-2].
- `conf_force`  in  1  sampled with `conf_data`; on acceptance, send every switch regardless of the shadow.
- `net_conf_bus_out`  out  `BUS_W`  registered bus word; connects to the network's `net_conf_bus_in`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when the last slot is on the bus.

## Operation
- Bus word format:
  - bit 0 = valid.
  - bits [`ID_W`:1] = switch ID.
  - bits [`ID_W`+`SEL_W`:`ID_W`+1] = setting.
  - All other bits 0.
  - Idle or skipped slot = all-zero word.
- FSM states:
  - IDLE: `conf_ready`=1. On `conf_valid`&`conf_ready`, latch `conf_data` into the hold register, latch `eff_force` = `conf_force` | !`shadow_valid`, clear idx, and go to SEND.
  - SEND: one slot per cycle for idx = 0..`NUM_SW`-1.
    - If `eff_force` is set or setting[idx] differs from shadow[idx], load the bus register with the valid word for ID idx+1 and set shadow[idx] to the new setting.
    - Otherwise load the zero word.
    - After idx = `NUM_SW`-1, go to DONE.
  - DONE: `done`=1 for this cycle, load the bus register with zero, set `shadow_valid`=1, and go to IDLE.
- Every slot costs exactly one cycle, whether the word is sent or skipped. Latency is therefore independent of the data.
- `conf_valid` outside IDLE is ignored; no data is latched. `conf_data` need not remain stable after acceptance.
- Slot order is always ascending switch ID.
- The shadow register is updated per slot at the clock edge that loads the corresponding word.

## Timing
- Cycle 0 is the cycle in which the handshake is sampled.
- SEND occupies cycles 1..12. The word for switch k is visible on `net_conf_bus_out` in cycle k+1 (cycles 2..13).
- DONE occurs in cycle 13; `done`=1 in the same cycle as the switch 12 word.
- Cycle 14: IDLE, bus is zero, `conf_ready`=1. The next acceptance can occur in cycle 14, giving 14-cycle throughput.
- `busy`=1 in cycles 1..13.
- Reset values:
  - State IDLE.
  - `net_conf_bus_out`=0, `done`=0, `busy`=0.
  - `conf_ready`=1 (handshakes ignored while `rst` is high).
  - Shadow=0, `shadow_valid`=0, idx=0.
- Reset asserted mid-SEND:
  - Bus goes to 0 immediately and the sequence aborts.
  - The shadow clears, so the next accepted configuration is a full rewrite.
- An accept in the same cycle as DONE is impossible, because `conf_ready`=0 in DONE.

## Test plan
- First configuration after reset, `conf_data`=24'h000000, `conf_force`=0 -> cycles 2..13 carry 12 valid words with IDs 1..12 and setting 0 (word for ID 1 = 64'h3); `done` in cycle 13; `conf_ready` returns in cycle 14.
- Second configuration differing only in switch 5 (setting 2'b11) -> only cycle 6 carries 64'h60B (ID 5, setting 3, valid); all other slots are 0; `done` is still in cycle 13.
- Identical configuration resent with `conf_force`=0 -> all 12 slots are zero and `done` pulses in cycle 13; with `conf_force`=1 -> all 12 words are sent.
- `conf_valid` held high with changing `conf_data` during cycles 1..13 -> no second acceptance, and words reflect only the cycle-0 data; acceptance occurs in cycle 14.
- `rst` pulsed during cycle 7 -> bus is 0 and `busy` is 0 immediately; the next unchanged configuration is sent in full (`shadow_valid` cleared).
- End-to-end: writer connected to the omega network, routing settings loaded -> after network settle, each `outN` carries the expected input per the programmed settings.
